// File: rtl/run_ctrl_if.sv
// run_ctrl_if: button inputs and counter-enable outputs of the run controller.
interface run_ctrl_if;
    logic BTN;
    logic STEP;
    logic CE;
    logic RUN;
    logic BTN_DB;
    modport master (output BTN, STEP, input CE, RUN, BTN_DB);
    modport slave (input BTN, STEP, output CE, RUN, BTN_DB);
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: debounced start/stop toggle and divided one-cycle CE pulse for the counter.
// Define RUN_CTRL_STEP_EN to add the single-step button (one CE pulse per STEP press in IDLE).
module run_ctrl #(
    parameter int DIV = 5000000,
    parameter int DB_CYCLES = 50000
) (
    input logic CLK,
    input logic R,
    run_ctrl_if.slave bus
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef RUN_CTRL_STEP_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif
    typedef enum logic {IDLE, RUNNING} state_t;
    logic [NCH-1:0] raw, s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbp_q, dbp_d, prs_q, prs_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    state_t state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic ce_q, ce_d, running, run_next, wrap, step_ce;
    // Channel 0 is BTN, channel 1 (when present) is STEP.
`ifdef RUN_CTRL_STEP_EN
    assign raw = {bus.STEP, bus.BTN};
    assign step_ce = prs_q[1] & ~running & ~prs_q[0];
`else
    logic unused_step;
    assign unused_step = bus.STEP;
    assign raw = bus.BTN;
    assign step_ce = 1'b0;
`endif
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        dbp_d = db_q;
        prs_d = db_q & ~dbp_q;
        db_d = db_q;
        cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = (s2_q[i] == db_q[i] || cnt_q[i] == CW'(DB_CYCLES - 1)) ? '0 : cnt_q[i] + CW'(1);
            db_d[i] = (s2_q[i] != db_q[i] && cnt_q[i] == CW'(DB_CYCLES - 1)) ? s2_q[i] : db_q[i];
        end
        running = state_q == RUNNING;
        state_d = prs_q[0] ? (running ? IDLE : RUNNING) : state_q;
        run_next = state_d == RUNNING;
        wrap = pre_q == PW'(DIV - 1);
        // Requiring running now as well as next keeps DIV=1 from pulsing on the start edge.
        pre_d = (running && run_next && !wrap) ? pre_q + PW'(1) : '0;
        ce_d = (running & run_next & wrap) | step_ce;
    end
    always_ff @(posedge CLK) begin
        if (R) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
            dbp_q <= '0;
            prs_q <= '0;
            cnt_q <= '0;
            state_q <= IDLE;
            pre_q <= '0;
            ce_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            db_q <= db_d;
            dbp_q <= dbp_d;
            prs_q <= prs_d;
            cnt_q <= cnt_d;
            state_q <= state_d;
            pre_q <= pre_d;
            ce_q <= ce_d;
        end
    end
    assign bus.CE = ce_q;
    assign bus.RUN = running;
    assign bus.BTN_DB = db_q[0];
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: random button stimulus on DIV=4 and DIV=1 instances against an event-time model.
module tb_run_ctrl;
    localparam int DB = 8;
    logic CLK = 1'b0;
    logic R = 1'b1;
    always #5 CLK = ~CLK;
    run_ctrl_if bus4 ();
    run_ctrl_if bus1 ();
    run_ctrl #(.DIV(4), .DB_CYCLES(DB)) u4 (.CLK(CLK), .R(R), .bus(bus4.slave));
    run_ctrl #(.DIV(1), .DB_CYCLES(DB)) u1 (.CLK(CLK), .R(R), .bus(bus1.slave));
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    int n_first, rise;
    bit s1b, s2b, db_m, run_m, ce4_m, ce1_m;
    bit win_b[$];
    int tog_q[$];
`ifdef RUN_CTRL_STEP_EN
    bit s1s, s2s, sdb_m;
    bit win_s[$];
    int stp_q[$];
`endif
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    // A level is accepted once the last DB synced samples all differ from the accepted level.
    function automatic bit stable(input bit q[$], input bit lvl);
        if (q.size() != DB) return 1'b0;
        foreach (q[i]) if (q[i] != lvl) return 1'b0;
        return 1'b1;
    endfunction
    task automatic model_edge(input bit b, input bit s, input bit r);
        bit in_b, run_before, btn_tog;
        cyc++;
        if (r) begin
            s1b = 0; s2b = 0; db_m = 0; run_m = 0; ce4_m = 0; ce1_m = 0;
            win_b.delete(); tog_q.delete();
`ifdef RUN_CTRL_STEP_EN
            s1s = 0; s2s = 0; sdb_m = 0;
            win_s.delete(); stp_q.delete();
`endif
            return;
        end
        in_b = s2b; s2b = s1b; s1b = b;
        win_b.push_back(in_b);
        if (win_b.size() > DB) void'(win_b.pop_front());
        if (stable(win_b, !db_m)) begin
            db_m = !db_m;
            win_b.delete();
            if (db_m) tog_q.push_back(cyc + 2);
        end
        run_before = run_m;
        btn_tog = 0;
        if (tog_q.size() > 0 && tog_q[0] == cyc) begin
            void'(tog_q.pop_front());
            btn_tog = 1;
            run_m = !run_m;
            if (run_m) t_start = cyc;
        end
        ce4_m = run_m && cyc > t_start && (cyc - t_start) % 4 == 0;
        ce1_m = run_m && cyc > t_start;
`ifdef RUN_CTRL_STEP_EN
        begin
            bit in_s;
            in_s = s2s; s2s = s1s; s1s = s;
            win_s.push_back(in_s);
            if (win_s.size() > DB) void'(win_s.pop_front());
            if (stable(win_s, !sdb_m)) begin
                sdb_m = !sdb_m;
                win_s.delete();
                if (sdb_m) stp_q.push_back(cyc + 2);
            end
            if (stp_q.size() > 0 && stp_q[0] == cyc) begin
                void'(stp_q.pop_front());
                if (!run_before && !btn_tog) begin
                    ce4_m = 1;
                    ce1_m = 1;
                end
            end
        end
`else
        if (s && run_before && btn_tog) ce1_m = ce1_m;
`endif
    endtask
    task automatic cycle(input bit b, input bit s, input bit r);
        bus4.BTN = b; bus1.BTN = b;
        bus4.STEP = s; bus1.STEP = s;
        R = r;
        @(posedge CLK);
        model_edge(b, s, r);
        #1;
        chk("ce_div4", 32'(bus4.CE), 32'(ce4_m));
        chk("ce_div1", 32'(bus1.CE), 32'(ce1_m));
        chk("run_div4", 32'(bus4.RUN), 32'(run_m));
        chk("run_div1", 32'(bus1.RUN), 32'(run_m));
        chk("btn_db_div4", 32'(bus4.BTN_DB), 32'(db_m));
        chk("btn_db_div1", 32'(bus1.BTN_DB), 32'(db_m));
    endtask
    initial begin
        repeat (5) cycle(1, 0, 1);
        n_first = cyc + 1;
        rise = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0);
            if (rise == 0 && bus4.RUN === 1'b1) rise = cyc;
        end
        chk("start_latency", 32'(rise - n_first), 32'(DB + 3));
        repeat (10) cycle(1, 0, 0);
        repeat (15) cycle(0, 0, 0);
        repeat (5) cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        repeat (20) cycle(1, 0, 0);
        repeat (15) cycle(0, 0, 0);
        repeat (13) cycle(1, 0, 0);
        repeat (6) cycle(0, 0, 0);
        repeat (12) cycle(1, 0, 0);
        repeat (15) cycle(0, 0, 0);
`ifdef RUN_CTRL_STEP_EN
        repeat (2) cycle(0, 0, 1);
        repeat (3) begin
            repeat (12) cycle(0, 1, 0);
            repeat (12) cycle(0, 0, 0);
        end
        repeat (12) cycle(1, 1, 0);
        repeat (12) cycle(0, 0, 0);
        repeat (12) cycle(0, 1, 0);
        repeat (12) cycle(0, 0, 0);
`endif
        for (int k = 0; k < 200; k++) begin
            bit lvl, sl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            sl = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 1) ? $urandom_range(1, 4) : $urandom_range(8, 24);
            repeat (len) cycle(lvl, sl, 0);
            if ($urandom_range(0, 39) == 0) repeat ($urandom_range(1, 3)) cycle(lvl, sl, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
